port_trace_capture: RTL and testbench

//  Parametrised run-control and trace block for sc1_cpu simulation/FPGA bring-up.

---
 rtl/port_trace_capture_pkg.sv | 31 +++
 rtl/port_trace_capture_if.sv | 30 +++
 rtl/port_trace_capture_trace_fifo.sv | 83 ++++++++
 rtl/port_trace_capture.sv | 210 +++++++++++++++++++++
 tb/tb_port_trace_capture.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/port_trace_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : port_trace_capture_pkg                                           |
// | Purpose : Shared types and helpers for the port trace capture block:       |
// |           run-control state encoding and record sizing functions.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package port_trace_capture_pkg;

  // Run-control states: reset hold, capturing, tick limit reached.
  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  // Width of the saturating dropped-change counter.
  localparam int DROP_BITS = 16;

  // Channel index width; a single channel still gets a 1-bit index field.
  function automatic int ch_bits_f(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Record layout, MSB to LSB: {tick, channel, value}.
  function automatic int rec_bits_f(input int tick_bits, input int channels, input int width);
    return tick_bits + ch_bits_f(channels) + width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_trace_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : port_trace_capture_if                                            |
// | Purpose : Trace record read port (valid/ready handshake).                  |
// |   rd_valid  master->slave  head record present                             |
// |   rd_ready  slave->master  reader accepts head                             |
// |   rd_tick   master->slave  head timestamp                                  |
// |   rd_chan   master->slave  head channel index                              |
// |   rd_data   master->slave  head channel value                              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface port_trace_capture_if
  import port_trace_capture_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TICK_BITS = 32,
  parameter int CH_BITS   = 1
) ();

  logic                 rd_valid;
  logic                 rd_ready;
  logic [TICK_BITS-1:0] rd_tick;
  logic [CH_BITS-1:0]   rd_chan;
  logic [WIDTH-1:0]     rd_data;

  modport master (output rd_valid, output rd_tick, output rd_chan, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_tick, input rd_chan, input rd_data, output rd_ready);

endinterface
`default_nettype wire

// File: rtl/port_trace_capture_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : trace_fifo                                                       |
// | Purpose : Synchronous FIFO with a registered head. Pointers carry an extra |
// |           wrap bit to tell full from empty.                                |
// |   clk, reset_n   clock, async active-low reset                             |
// |   push, push_data  write request (ignored when full)                       |
// |   full           no space; a pop in the same cycle does not make room     |
// |   pop_ready      reader accepts head (pop when out_valid & pop_ready)      |
// |   out_valid, out_data  registered head                                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module trace_fifo
  import port_trace_capture_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  output logic                  full,
  input  wire logic             pop_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    head_q, head_d;
  logic                do_push;
  logic                do_pop;

  assign full    = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
  assign do_push = push && !full;
  assign do_pop  = valid_q && pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{DEPTH_BITS{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{DEPTH_BITS{1'b0}}, do_pop};
    valid_d  = (wr_ptr_d != rd_ptr_d);
    head_d   = head_q;
    if (valid_d) begin
      // The next head is the slot being written this edge: bypass the memory.
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = push_data;
      end else begin
        head_d = mem[rd_ptr_d[DEPTH_BITS-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[DEPTH_BITS-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/port_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : port_trace_capture                                               |
// | Purpose : Run control and port trace for CPU bring-up. Holds the CPU in    |
// |           reset, counts run ticks to a limit and queues timestamped        |
// |           change records of the watched channels for a reader.            |
// |   clk, reset_n  clock, async active-low reset                              |
// |   ch_in         watched values, channel k = ch_in[k*WIDTH +: WIDTH]         |
// |   dut_reset     active-high reset for the CPU                              |
// |   running/done  capturing / tick limit reached (sticky)                    |
// |   tick          ticks since dut_reset fell                                 |
// |   overflow      sticky, a pending change was overwritten                   |
// |   drop_count    saturating count of overwritten changes                    |
// |   rd            record read port (master side)                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module port_trace_capture
  import port_trace_capture_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CHANNELS     = 2,
  parameter int DEPTH_BITS   = 4,
  parameter int TICK_BITS    = 32,
  parameter int MAX_TICKS    = 4000,
  parameter int RESET_CYCLES = 2
) (
  input  wire logic                      clk,
  input  wire logic                      reset_n,
  input  wire logic [WIDTH*CHANNELS-1:0] ch_in,
  output logic                           dut_reset,
  output logic                           running,
  output logic                           done,
  output logic [TICK_BITS-1:0]           tick,
  output logic                           overflow,
  output logic [DROP_BITS-1:0]           drop_count,
  port_trace_capture_if.master           rd
);

  localparam int CH_BITS   = ch_bits_f(CHANNELS);
  localparam int REC_BITS  = rec_bits_f(TICK_BITS, CHANNELS, WIDTH);
  localparam int HOLD_BITS = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(RESET_CYCLES - 1);
  localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(MAX_TICKS - 1);

  state_t                 state_q, state_d;
  logic [HOLD_BITS-1:0]   hold_q, hold_d;
  logic [TICK_BITS-1:0]   tick_q, tick_d;
  logic                   dut_reset_q, dut_reset_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   first_q, first_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_BITS-1:0]   drop_count_q, drop_count_d;

  logic [WIDTH-1:0]       last_q [CHANNELS];
  logic [WIDTH-1:0]       last_d [CHANNELS];
  logic [WIDTH-1:0]       pval_q [CHANNELS];
  logic [WIDTH-1:0]       pval_d [CHANNELS];
  logic [TICK_BITS-1:0]   ptick_q [CHANNELS];
  logic [TICK_BITS-1:0]   ptick_d [CHANNELS];
  logic [CHANNELS-1:0]    pend_q, pend_d;

  logic                   run_en;
  logic                   drain_en;
  logic [CHANNELS-1:0]    grant;
  logic                   push;
  logic [REC_BITS-1:0]    push_rec;
  logic                   fifo_full;
  logic [REC_BITS-1:0]    head_rec;
  logic [4:0]             n_drops;
  logic [DROP_BITS:0]     drop_sum;

  assign run_en   = (state_q == ST_RUN);
  assign drain_en = (state_q == ST_RUN) || (state_q == ST_DONE);

  // Run-control next state.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    tick_d      = tick_q;
    dut_reset_d = dut_reset_q;
    running_d   = running_q;
    done_d      = done_q;
    first_d     = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d     = ST_RUN;
          dut_reset_d = 1'b0;
          running_d   = 1'b1;
          first_d     = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        tick_d = tick_q + 1'b1;
        // The terminal edge still increments, so tick reads MAX_TICKS in DONE.
        if ((MAX_TICKS != 0) && (tick_q == TICK_LAST)) begin
          state_d   = ST_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      ST_DONE: ;
      default: state_d = ST_RST_HOLD;
    endcase
  end

  // Priority arbiter: lowest-index pending channel wins the single push slot.
  always_comb begin
    grant    = '0;
    push     = 1'b0;
    push_rec = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!push && drain_en && !fifo_full && pend_q[k]) begin
        push     = 1'b1;
        grant[k] = 1'b1;
        push_rec = {ptick_q[k], CH_BITS'(k), pval_q[k]};
      end
    end
  end

  // Change detection; a change on the same edge as a grant re-arms the slot
  // without counting as a drop.
  always_comb begin
    pend_d  = pend_q & ~grant;
    last_d  = last_q;
    pval_d  = pval_q;
    ptick_d = ptick_q;
    n_drops = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (run_en) begin
        last_d[k] = ch_in[k*WIDTH +: WIDTH];
        if (first_q || (ch_in[k*WIDTH +: WIDTH] != last_q[k])) begin
          if (pend_q[k] && !grant[k]) begin
            n_drops = n_drops + 5'd1;
          end
          pend_d[k]  = 1'b1;
          pval_d[k]  = ch_in[k*WIDTH +: WIDTH];
          ptick_d[k] = tick_q;
        end
      end
    end
    drop_sum     = {1'b0, drop_count_q} + {{(DROP_BITS-4){1'b0}}, n_drops};
    drop_count_d = drop_sum[DROP_BITS] ? {DROP_BITS{1'b1}} : drop_sum[DROP_BITS-1:0];
    overflow_d   = overflow_q || (n_drops != 5'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST_HOLD;
      hold_q       <= '0;
      tick_q       <= '0;
      dut_reset_q  <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      first_q      <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      pend_q       <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        last_q[k]  <= '0;
        pval_q[k]  <= '0;
        ptick_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      tick_q       <= tick_d;
      dut_reset_q  <= dut_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
      first_q      <= first_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      pend_q       <= pend_d;
      last_q       <= last_d;
      pval_q       <= pval_d;
      ptick_q      <= ptick_d;
    end
  end

  trace_fifo #(
    .WIDTH      (REC_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_rec),
    .full      (fifo_full),
    .pop_ready (rd.rd_ready),
    .out_valid (rd.rd_valid),
    .out_data  (head_rec)
  );

  assign rd.rd_tick  = head_rec[REC_BITS-1 -: TICK_BITS];
  assign rd.rd_chan  = head_rec[WIDTH +: CH_BITS];
  assign rd.rd_data  = head_rec[WIDTH-1:0];

  assign dut_reset   = dut_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign tick        = tick_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_port_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_port_trace_capture                                            |
// | Purpose : Self-checking bench. Instance A: 4-deep FIFO, free-running       |
// |           ticks. Instance B: 16-deep FIFO, 8-tick run limit. Expected      |
// |           records are queued when stimulus is driven and compared as the   |
// |           DUT hands them out.                                              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_port_trace_capture;

  typedef struct packed {
    logic [31:0] t;
    logic        c;
    logic [31:0] d;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_na, reset_nb;
  logic [63:0] ch_a, ch_b;
  logic        dut_reset_a, running_a, done_a, overflow_a;
  logic        dut_reset_b, running_b, done_b, overflow_b;
  logic [31:0] tick_a, tick_b;
  logic [15:0] drop_a, drop_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_tick;
  rec_t exp_q[$];
  rec_t got, e;

  port_trace_capture_if #(.WIDTH(32), .TICK_BITS(32), .CH_BITS(1)) rda ();
  port_trace_capture_if #(.WIDTH(32), .TICK_BITS(32), .CH_BITS(1)) rdb ();

  port_trace_capture #(
    .WIDTH(32), .CHANNELS(2), .DEPTH_BITS(2), .TICK_BITS(32), .MAX_TICKS(0), .RESET_CYCLES(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_na), .ch_in(ch_a), .dut_reset(dut_reset_a), .running(running_a),
    .done(done_a), .tick(tick_a), .overflow(overflow_a), .drop_count(drop_a), .rd(rda)
  );

  port_trace_capture #(
    .WIDTH(32), .CHANNELS(2), .DEPTH_BITS(4), .TICK_BITS(32), .MAX_TICKS(8), .RESET_CYCLES(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_nb), .ch_in(ch_b), .dut_reset(dut_reset_b), .running(running_b),
    .done(done_b), .tick(tick_b), .overflow(overflow_b), .drop_count(drop_b), .rd(rdb)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input int t, input int c, input int d);
    rec_t r;
    r.t = 32'(t);
    r.c = 1'(c);
    r.d = 32'(d);
    return r;
  endfunction

  // Reset instance A with the given channel values and return on the first
  // RUN cycle (tick 0), sampling at the falling edge.
  task automatic start_run_a(input logic [63:0] init);
    reset_na = 1'b0;
    ch_a = init;
    rda.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_na = 1'b1;
    repeat (2) @(negedge clk);
    cur_tick = 0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset_na = 1'b0;
    ch_a = '0;
    rda.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (dut_reset_a !== 1'b1) begin n_fail++; $display("FAIL reset_dut_reset: got %b want 1", dut_reset_a); end
    n_tests++; if (running_a !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_tests++; if (tick_a !== 32'd0) begin n_fail++; $display("FAIL reset_tick: got %0d want 0", tick_a); end
    n_tests++; if (rda.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rda.rd_valid); end
    n_tests++; if ({rda.rd_tick, rda.rd_chan, rda.rd_data} !== 65'd0) begin n_fail++; $display("FAIL reset_rd_fields: got %h want 0", {rda.rd_tick, rda.rd_chan, rda.rd_data}); end
    n_tests++; if ({overflow_a, drop_a} !== 17'd0) begin n_fail++; $display("FAIL reset_drop: got ovf=%b cnt=%0d want 0/0", overflow_a, drop_a); end
    reset_na = 1'b1;
    @(negedge clk);
    n_tests++; if (dut_reset_a !== 1'b1) begin n_fail++; $display("FAIL hold_edge1: got dut_reset=%b want 1", dut_reset_a); end
    @(negedge clk);
    n_tests++; if (dut_reset_a !== 1'b0 || running_a !== 1'b1) begin n_fail++; $display("FAIL hold_edge2: got dut_reset=%b running=%b want 0/1", dut_reset_a, running_a); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (tick_a !== 32'(i)) begin n_fail++; $display("FAIL run_tick%0d: got %0d want %0d", i, tick_a, i); end
      @(negedge clk);
    end
  endtask

  task automatic test_static;
    start_run_a({32'd0, 32'd5});
    rda.rd_ready = 1'b1;
    exp_q.push_back(mk(0, 0, 5));
    exp_q.push_back(mk(0, 1, 0));
    for (int c = 0; c < 20; c++) begin
      if (rda.rd_valid && rda.rd_ready) begin
        got = {rda.rd_tick, rda.rd_chan, rda.rd_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL static_extra: got t=%0d c=%0d d=%0d want no record", got.t, got.c, got.d);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL static_rec: got t=%0d c=%0d d=%0d want t=%0d c=%0d d=%0d", got.t, got.c, got.d, e.t, e.c, e.d); end
        end
      end
      @(negedge clk); cur_tick++;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL static_missing: got %0d left want 0", exp_q.size()); end
    n_tests++; if (rda.rd_valid !== 1'b0) begin n_fail++; $display("FAIL static_empty: got rd_valid=%b want 0", rda.rd_valid); end
  endtask

  task automatic test_simultaneous;
    start_run_a(64'd0);
    rda.rd_ready = 1'b1;
    exp_q.push_back(mk(0, 0, 0));
    exp_q.push_back(mk(0, 1, 0));
    for (int c = 0; c < 30; c++) begin
      if (rda.rd_valid && rda.rd_ready) begin
        got = {rda.rd_tick, rda.rd_chan, rda.rd_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL simul_extra: got t=%0d c=%0d d=%0d want no record", got.t, got.c, got.d);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL simul_rec: got t=%0d c=%0d d=%0d want t=%0d c=%0d d=%0d", got.t, got.c, got.d, e.t, e.c, e.d); end
        end
      end
      if (cur_tick == 10) begin
        ch_a = {32'd9, 32'd7};
        exp_q.push_back(mk(10, 0, 7));
        exp_q.push_back(mk(10, 1, 9));
      end
      @(negedge clk); cur_tick++;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_overflow;
    start_run_a({32'd0, 32'd100});
    rda.rd_ready = 1'b0;
    while (cur_tick <= 11) begin
      if (cur_tick == 5) begin
        n_tests++; if (overflow_a !== 1'b0 || drop_a !== 16'd0) begin n_fail++; $display("FAIL ovf_t5: got ovf=%b cnt=%0d want 0/0", overflow_a, drop_a); end
      end
      if (cur_tick == 6) begin
        n_tests++; if (overflow_a !== 1'b1 || drop_a !== 16'd1) begin n_fail++; $display("FAIL ovf_t6: got ovf=%b cnt=%0d want 1/1", overflow_a, drop_a); end
        n_tests++; if (rda.rd_valid !== 1'b1 || rda.rd_data !== 32'd100) begin n_fail++; $display("FAIL ovf_head: got v=%b d=%0d want 1/100", rda.rd_valid, rda.rd_data); end
      end
      if (cur_tick == 10) begin
        n_tests++; if (drop_a !== 16'd5) begin n_fail++; $display("FAIL ovf_t10: got cnt=%0d want 5", drop_a); end
      end
      ch_a[31:0] = 32'(100 + cur_tick);
      if (cur_tick <= 3) exp_q.push_back(mk(cur_tick, 0, 100 + cur_tick));
      @(negedge clk); cur_tick++;
    end
    // The latest overwrite of ch0 survives, then the starved ch1 record.
    exp_q.push_back(mk(11, 0, 111));
    exp_q.push_back(mk(0, 1, 0));
    n_tests++; if (drop_a !== 16'd7) begin n_fail++; $display("FAIL ovf_total: got cnt=%0d want 7", drop_a); end
    rda.rd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rda.rd_valid && rda.rd_ready) begin
        got = {rda.rd_tick, rda.rd_chan, rda.rd_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL ovf_extra: got t=%0d c=%0d d=%0d want no record", got.t, got.c, got.d);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL ovf_rec: got t=%0d c=%0d d=%0d want t=%0d c=%0d d=%0d", got.t, got.c, got.d, e.t, e.c, e.d); end
        end
      end
      @(negedge clk); cur_tick++;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_missing: got %0d left want 0", exp_q.size()); end
    n_tests++; if (drop_a !== 16'd7) begin n_fail++; $display("FAIL ovf_final: got cnt=%0d want 7", drop_a); end
  endtask

  task automatic test_done;
    reset_nb = 1'b0;
    ch_b = 64'd0;
    rdb.rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_nb = 1'b1;
    repeat (2) @(negedge clk);
    cur_tick = 0;
    exp_q.delete();
    exp_q.push_back(mk(0, 0, 0));
    exp_q.push_back(mk(0, 1, 0));
    while (cur_tick <= 14) begin
      if (rdb.rd_valid && rdb.rd_ready) begin
        got = {rdb.rd_tick, rdb.rd_chan, rdb.rd_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL done_extra: got t=%0d c=%0d d=%0d want no record", got.t, got.c, got.d);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL done_rec: got t=%0d c=%0d d=%0d want t=%0d c=%0d d=%0d", got.t, got.c, got.d, e.t, e.c, e.d); end
        end
      end
      if (cur_tick == 7) begin
        n_tests++; if (done_b !== 1'b0 || running_b !== 1'b1 || tick_b !== 32'd7) begin n_fail++; $display("FAIL done_t7: got done=%b run=%b tick=%0d want 0/1/7", done_b, running_b, tick_b); end
        ch_b = {32'd2, 32'd1};
        exp_q.push_back(mk(7, 0, 1));
        exp_q.push_back(mk(7, 1, 2));
      end
      if (cur_tick == 8) begin
        n_tests++; if (done_b !== 1'b1 || running_b !== 1'b0 || tick_b !== 32'd8) begin n_fail++; $display("FAIL done_t8: got done=%b run=%b tick=%0d want 1/0/8", done_b, running_b, tick_b); end
      end
      if (cur_tick == 9) ch_b = {32'd4, 32'd3};
      if (cur_tick == 14) begin
        n_tests++; if (tick_b !== 32'd8 || done_b !== 1'b1) begin n_fail++; $display("FAIL done_frozen: got tick=%0d done=%b want 8/1", tick_b, done_b); end
      end
      @(negedge clk); cur_tick++;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL done_missing: got %0d left want 0", exp_q.size()); end
    n_tests++; if (rdb.rd_valid !== 1'b0) begin n_fail++; $display("FAIL done_empty: got rd_valid=%b want 0", rdb.rd_valid); end
  endtask

  task automatic test_async_reset;
    start_run_a({32'd0, 32'd100});
    while (cur_tick < 9) begin
      ch_a[31:0] = 32'(100 + cur_tick);
      @(negedge clk); cur_tick++;
    end
    n_tests++; if (rda.rd_valid !== 1'b1 || drop_a !== 16'd4) begin n_fail++; $display("FAIL areset_pre: got v=%b cnt=%0d want 1/4", rda.rd_valid, drop_a); end
    reset_na = 1'b0;
    #1;
    n_tests++; if (rda.rd_valid !== 1'b0 || rda.rd_data !== 32'd0) begin n_fail++; $display("FAIL areset_rd: got v=%b d=%0d want 0/0", rda.rd_valid, rda.rd_data); end
    n_tests++; if (dut_reset_a !== 1'b1 || running_a !== 1'b0) begin n_fail++; $display("FAIL areset_ctl: got dut_reset=%b run=%b want 1/0", dut_reset_a, running_a); end
    n_tests++; if (tick_a !== 32'd0 || drop_a !== 16'd0 || overflow_a !== 1'b0) begin n_fail++; $display("FAIL areset_cnt: got tick=%0d cnt=%0d ovf=%b want 0/0/0", tick_a, drop_a, overflow_a); end
    @(negedge clk);
  endtask

  initial begin
    reset_na = 1'b0;
    reset_nb = 1'b0;
    ch_a = '0;
    ch_b = '0;
    rda.rd_ready = 1'b0;
    rdb.rd_ready = 1'b0;
    cur_tick = 0;
    @(negedge clk);
    test_reset();
    test_static();
    test_simultaneous();
    test_overflow();
    test_done();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
